// File: rtl/ntt_loop_sequencer_if.sv
// Handshake and index bus between the NTT issue sequencer and its address generators.
interface ntt_loop_sequencer_if;
   logic       start;
   logic       stall;
   logic       busy;
   logic       done;
   logic       stage_done;
   logic       rd_valid;
   logic [4:0] i;
   logic [4:0] k;
   logic [4:0] j;
   logic [3:0] p;
   logic       wb_valid;
   logic [4:0] wb_i;
   logic [4:0] wb_k;
   logic [4:0] wb_j;
   logic [3:0] wb_p;

   modport master (
      input  start, stall,
      output busy, done, stage_done, rd_valid, i, k, j, p,
      output wb_valid, wb_i, wb_k, wb_j, wb_p
   );

   modport slave (
      output start, stall,
      input  busy, done, stage_done, rd_valid, i, k, j, p,
      input  wb_valid, wb_i, wb_k, wb_j, wb_p
   );
endinterface

// File: rtl/ntt_loop_sequencer.sv
// Issue-side sequencer for the 128-point NTT: walks four butterfly stages,
// emits one {i,k,j,p} read tuple per cycle, and delays it by LAT cycles to
// form the write-back tuple. Each stage drains the pipeline before the next.
module ntt_loop_sequencer #(
   parameter int LAT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   ntt_loop_sequencer_if.master bus
);

   localparam int             TW         = 20;
   localparam logic [3:0]     DRAIN_LAST = 4'(LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t     state;
   logic [4:0] i_q, k_q, j_q;
   logic [3:0] p_q;
   logic [3:0] dcnt;
   logic       busy_q, done_q, sd_q;
   logic [4:0] j_lim;
   logic       rd_valid;
   logic [TW-1:0] dline [LAT];

   // j wrap limit for the current stage: 4^p - 1 (stage 3 never advances j)
   always_comb begin
      j_lim = 5'd0;
      case (p_q)
         4'd1:    j_lim = 5'd3;
         4'd2:    j_lim = 5'd15;
         default: j_lim = 5'd0;
      endcase
   end

   // A stalled issue cycle shows the held tuple but is not a live butterfly
   assign rd_valid = (state == ISSUE) && !bus.stall;

   // Stage/index FSM; drain counter counts down so the last drain cycle is dcnt == 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         i_q    <= '0;
         k_q    <= '0;
         j_q    <= '0;
         p_q    <= '0;
         dcnt   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sd_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         sd_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= ISSUE;
                  busy_q <= 1'b1;
               end
            end
            ISSUE: begin
               if (!bus.stall) begin
                  if (i_q == 5'd31) begin
                     // i=31 is terminal: hold the tuple and drain the pipeline
                     state  <= DRAIN;
                     dcnt   <= DRAIN_LAST;
                     sd_q   <= (DRAIN_LAST == 4'd0);
                     done_q <= (DRAIN_LAST == 4'd0) && (p_q == 4'd3);
                  end else begin
                     i_q <= i_q + 5'd1;
                     if (p_q != 4'd3) begin
                        if (j_q == j_lim) begin
                           j_q <= 5'd0;
                           k_q <= k_q + 5'd1;
                        end else begin
                           j_q <= j_q + 5'd1;
                        end
                     end
                  end
               end
            end
            DRAIN: begin
               if (dcnt == 4'd0) begin
                  i_q <= '0;
                  k_q <= '0;
                  j_q <= '0;
                  if (p_q == 4'd3) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                     p_q    <= '0;
                  end else begin
                     state <= ISSUE;
                     p_q   <= p_q + 4'd1;
                  end
               end else begin
                  dcnt   <= dcnt - 4'd1;
                  sd_q   <= (dcnt == 4'd1);
                  done_q <= (dcnt == 4'd1) && (p_q == 4'd3);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write-back delay line: shifts every cycle, bubbles included
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int n = 0; n < LAT; n++) dline[n] <= '0;
      end else begin
         dline[0] <= {rd_valid, i_q, k_q, j_q, p_q};
         for (int n = 1; n < LAT; n++) dline[n] <= dline[n-1];
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.stage_done = sd_q;
   assign bus.rd_valid   = rd_valid;
   assign bus.i          = i_q;
   assign bus.k          = k_q;
   assign bus.j          = j_q;
   assign bus.p          = p_q;
   assign {bus.wb_valid, bus.wb_i, bus.wb_k, bus.wb_j, bus.wb_p} = dline[LAT-1];

endmodule

// File: doc/ntt_loop_sequencer.md
# ntt_loop_sequencer

Issue-side sequencer for the 128-point mixed-radix NTT datapath. It walks the four butterfly stages in order and emits the `{i, k, j, p}` index tuple that drives the read-address generator, one butterfly per cycle. It delays each issued tuple by the butterfly pipeline latency to produce a matching write-back tuple for the write-side address generator. Between stages it drains the pipeline so that no stage reads data that has not yet been written back.

## Interface
Parameters:
- `LAT`, default 4: butterfly pipeline latency in cycles, from read-tuple issue to write-back. Legal range 1..15.

Ports:
- `clk` — input, 1 — single clock; all state changes on the rising edge.
- `rst` — input, 1 — synchronous, active-low reset.
- `start` — input, 1 — one-cycle request to begin a transform. Sampled only in IDLE.
- `stall` — input, 1 — freezes issue while high during ISSUE.
- `busy` — output, 1 — high from the cycle after an accepted start through the `done` cycle.
- `done` — output, 1 — one-cycle pulse at the completion of stage 3.
- `stage_done` — output, 1 — one-cycle pulse at the end of each stage's drain.
- `rd_valid` — output, 1 — the current rd tuple is a live butterfly.
- `i` — output, 5 — butterfly index within the stage, 0..31.
- `k` — output, 5 — group index.
- `j` — output, 5 — offset within group.
- `p` — output, 4 — stage number, 0..3.
- `wb_valid`, `wb_i` (5), `wb_k` (5), `wb_j` (5), `wb_p` (4) — outputs: the rd tuple and `rd_valid` delayed by exactly `LAT` cycles.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE → ISSUE when `start` = 1. The first tuple is {p=0, k=0, j=0, i=0}.
- Per-stage index ranges (4^p-stride radix-4 groups):
  - p=0: j = 0, k = 0..31.
  - p=1: j = 0..3, k = 0..7.
  - p=2: j = 0..15, k = 0..1.
  - p=3: k = 0 and j = 0 throughout; only `i` runs.
- Index order within a stage:
  - `j` is the inner index and `k` the outer.
  - For p<3: when j reaches 4^p−1, j wraps to 0 and k increments.
  - `i` increments on every issued butterfly in every stage.
  - Exactly 32 butterflies are issued per stage.
- Stall: in ISSUE, `stall` = 1 holds all of {i, k, j, p}, forces `rd_valid` = 0 for that cycle, and inserts a bubble into the delay line.
- After the stage's i=31 tuple is issued, the next state is DRAIN. `rd_valid` = 0 throughout DRAIN; `stall` is ignored there.
- The drain counter runs LAT cycles.
- On the last drain cycle:
  - `stage_done` = 1.
  - This is the same cycle in which the i=31 write-back appears on `wb_*`.
  - If p<3: next state ISSUE with p+1 and i, k, j cleared.
  - If p=3: `done` = 1 and the next state is IDLE.
- While in DRAIN, rd tuple outputs hold their last issued values. In IDLE they are all 0.
- `start` while `busy` = 1 is ignored; no restart and no queuing.
- Delay line: a LAT-deep shift register of {valid, i, k, j, p}. It shifts every cycle regardless of state or stall.
- Arithmetic rules:
  - All counters are unsigned.
  - The j wrap limit is (1 << (2p)) − 1, evaluated only for p<3.
  - No counter exceeds its range; i=31 is terminal, not wrapping.

## Timing
- Reset (`rst` = 0 at an edge) forces, in the next cycle:
  - State IDLE.
  - `busy`, `done`, `stage_done`, `rd_valid` = 0.
  - i, k, j, p = 0.
  - All delay-line entries cleared: `wb_valid` = 0 and wb tuple = 0.
- Reset mid-transform aborts immediately, with no `done` and no `stage_done`.
- Let the `start` edge be at cycle S.
  - First issue: `rd_valid` = 1 at cycle S+1; `busy` = 1 from S+1.
  - Stage n has its first issue at cycle S+1+n·(32+LAT) when there are no stalls.
  - The last issue of stage 3 is at cycle S+4·32+3·LAT.
  - `done` is at cycle S+4·(32+LAT), with `busy` = 1 in that cycle.
  - `busy` = 0 and state IDLE at cycle S+4·(32+LAT)+1.
- Each stall cycle adds exactly one cycle to the schedule.
- Latency rule: `wb_*` at cycle t equals rd `{rd_valid, i, k, j, p}` at cycle t−LAT.
- `start` in the same cycle as `done` is ignored, because `busy` = 1. A `start` one cycle later is accepted.

## Test plan
- LAT=4, single start, no stalls:
  - Expect 128 `rd_valid` cycles.
  - Sequence p1 begins (k,j) = (0,0),(0,1),(0,2),(0,3),(1,0).
  - p2 j runs 0..15 with k = 0, then 0..15 with k = 1.
  - `stage_done` at S+36, S+72, S+108, S+144; `done` at S+144.
- LAT=4, `stall` high 3 cycles at p=1 i=10:
  - The tuple holds i=10, `rd_valid` = 0 for those 3 cycles.
  - `wb_valid` shows a 3-cycle gap 4 cycles later.
  - `done` at S+147.
- Pulse `start` at p=2 i=5 and again in the `done` cycle: both ignored, and the tuple sequence is unchanged.
- Drive `rst` = 0 at p=3 i=7:
  - All outputs and `wb_valid` are 0 the next cycle.
  - No `done`.
  - A new `start` yields p=0 i=0.
- LAT=1:
  - `wb_*` equals rd delayed 1 cycle.
  - Each stage spans 33 cycles; `done` at S+132.
- Check the last tuple of each stage (no stalls, LAT=4):
  - p0 ends (k=31, j=0).
  - p1 ends (k=7, j=3).
  - p2 ends (k=1, j=15).
  - p3 ends (i=31, k=0, j=0).
  - `rd_valid` = 0 during drain and `stall` is ignored there.
